// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
// Iterative multiply/divide unit with an integrated HI/LO register pair for
// the EX stage. MULT/MULTU use one shift-add step per cycle; DIV/DIVU use one
// restoring shift-subtract step per cycle on operand magnitudes, followed by
// a sign-fix cycle. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   start    one-cycle request, honoured only in IDLE
//   op       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b     rs / rt operands
//   abort    cancels the operation in flight (pipeline flush)
//   busy     operation in flight (PREP, CALC or FIX)
//   done     one-cycle pulse after HI/LO are written by MULT/DIV
//   div_zero last completed DIV/DIVU had b == 0
//   hi, lo   architectural HI/LO registers
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;      // op[1] = divide, op[0] = unsigned
  logic [WIDTH-1:0] a_q;       // raw dividend, kept for the divide-by-zero result
  logic [WIDTH-1:0] b_q;       // raw b until PREP, then its magnitude
  logic             b_zero;
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] shreg;     // multiplier -> product low half / dividend -> quotient
  logic             neg_res;   // negate product or quotient in FIX
  logic             neg_rem;   // negate remainder in FIX

  logic             sgn;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_geq;
  logic [WIDTH-1:0] rem_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // NOTE: every variable assigned in an always_comb gets a default first so
  // that no path leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !abort && !op[2]) state_next = PREP;
      PREP: state_next = CALC;
      CALC: if (count == LAST) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A flush cancels any operation in flight, including the write in FIX.
    if (abort && state != IDLE) state_next = IDLE;
  end

  assign busy = (state != IDLE);
  assign sgn  = ~op_q[0];

  // One iteration of each algorithm, both on unsigned magnitudes.
  always_comb begin
    mul_sum  = shreg[0] ? ({1'b0, acc} + {1'b0, b_q}) : {1'b0, acc};
    rem_sh   = {acc, shreg[WIDTH-1]};
    rem_geq  = (rem_sh >= {1'b0, b_q});
    // The true difference is below 2^WIDTH whenever it is taken, so the low
    // WIDTH bits are exact.
    rem_diff = rem_sh[WIDTH-1:0] - b_q;
    prod     = {acc, shreg};
    prod_s   = neg_res ? -prod : prod;
    quo_s    = neg_res ? -shreg : shreg;
    rem_s    = neg_rem ? -acc : acc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      b_zero   <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (!op[2]) begin
              op_q   <= op[1:0];
              a_q    <= a;
              b_q    <= b;
              b_zero <= (b == '0);
            end else if (op[1:0] == 2'b00) begin
              hi <= a;
            end else if (op[1:0] == 2'b01) begin
              lo <= a;
            end
          end
        end
        PREP: begin
          neg_res <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= sgn & a_q[WIDTH-1];
          shreg   <= (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
          b_q     <= (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
          acc     <= '0;
          count   <= '0;
        end
        CALC: begin
          count <= count + 1'b1;
          if (op_q[1]) begin
            if (rem_geq) begin
              acc   <= rem_diff;
              shreg <= {shreg[WIDTH-2:0], 1'b1};
            end else begin
              acc   <= rem_sh[WIDTH-1:0];
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc   <= mul_sum[WIDTH:1];
            shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (op_q[1]) begin
              div_zero <= b_zero;
              if (b_zero) begin
                lo <= '1;
                hi <= a_q;
              end else begin
                lo <= quo_s;
                hi <= rem_s;
              end
            end else begin
              {hi, lo} <= prod_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH = 32). Expected HI/LO values
// come from a plain-arithmetic reference model; directed cases cover the
// listed scenarios, followed by a randomized sequence of operations.
module tb_muldiv_hilo_unit;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] hi_m, lo_m;
  logic         dz_m;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural result of one completed operation.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sp;
    logic [63:0] up;
    case (o)
      3'b000: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {hi_m, lo_m} = sp;
      end
      3'b001: begin
        up = {32'b0, x} * {32'b0, y};
        {hi_m, lo_m} = up;
      end
      3'b010, 3'b011: begin
        if (y == 0) begin
          lo_m = '1;
          hi_m = x;
          dz_m = 1'b1;
        end else begin
          dz_m = 1'b0;
          if (o == 3'b011) begin
            lo_m = x / y;
            hi_m = x % y;
          end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            lo_m = x;
            hi_m = '0;
          end else begin
            lo_m = $signed(x) / $signed(y);
            hi_m = $signed(x) % $signed(y);
          end
        end
      end
      3'b100: hi_m = x;
      3'b101: lo_m = x;
      default: ;
    endcase
  endfunction

  // MULT/DIV family: checks busy, hold of HI/LO, latency, result, done pulse.
  // inject_at >= 0 raises a second (ignored) MTHI start at that cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string name, input int inject_at);
    logic [W-1:0] hi_old, lo_old;
    int cycles;
    bit held;
    hi_old = hi_m;
    lo_old = lo_m;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    model(o, x, y);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy after start: got %b want 1", name, busy);
    end
    cycles = 0;
    held = 1'b1;
    while (done !== 1'b1 && cycles < 100) begin
      if (hi !== hi_old || lo !== lo_old) held = 1'b0;
      if (cycles == inject_at) begin
        start = 1'b1; op = 3'b100; a = ~x;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s hold: hi/lo changed before done (want %h/%h)", name, hi_old, lo_old);
    end
    vectors++;
    if (cycles != LAT) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d cycles, want %0d", name, cycles, LAT);
    end
    vectors++;
    if (hi !== hi_m || lo !== lo_m) begin
      miscompares++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, hi_m, lo_m);
    end
    vectors++;
    if (div_zero !== dz_m || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s flags: div_zero=%b busy=%b want div_zero=%b busy=0", name, div_zero, busy, dz_m);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done pulse width: done=%b want 0", name, done);
    end
  endtask

  // MTHI/MTLO/no-op (optionally with abort asserted alongside start).
  task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x, input logic ab, input string name);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = $urandom; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    if (!ab) model(o, x, b);
    vectors++;
    if (hi !== hi_m || lo !== lo_m || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h busy=0 done=0",
               name, hi, lo, busy, done, hi_m, lo_m);
    end
  endtask

  // Cancel an operation at cycle 'at' after the start edge, by abort or by rst.
  task automatic run_cancel(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int at, input logic use_rst, input string name);
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    repeat (at) @(negedge clk);
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    if (use_rst) begin
      hi_m = '0; lo_m = '0; dz_m = 1'b0;
    end
    vectors++;
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m || div_zero !== dz_m) begin
      miscompares++;
      $display("FAIL %s: busy=%b hi=%h lo=%h dz=%b want busy=0 hi=%h lo=%h dz=%b",
               name, busy, hi, lo, div_zero, hi_m, lo_m, dz_m);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (saw_done || hi !== hi_m || lo !== lo_m) begin
      miscompares++;
      $display("FAIL %s quiet: done/busy seen=%b hi=%h lo=%h want none, %h/%h",
               name, saw_done, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    vectors++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b want all 0", hi, lo, busy, done, div_zero);
    end
  endtask

  task automatic test_divide();
    run_op(3'b011, 32'd100, 32'd7, "divu_100_7", -1);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_m7_2", -1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", -1);
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, "div_7_m2", -1);
    run_op(3'b011, 32'h1234, 32'd0, "divu_by_zero", -1);
    run_op(3'b000, 32'd3, 32'd5, "mult_keeps_dz", -1);
    run_op(3'b011, 32'd9, 32'd3, "divu_9_3", -1);
    run_op(3'b010, 32'hFFFF_FFF0, 32'd0, "div_by_zero_neg", -1);
  endtask

  task automatic test_multiply();
    run_op(3'b000, 32'hFFFF_FFFF, 32'd2, "mult_m1_2", -1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, "multu_ffff_2", -1);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min_min", -1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max_max", -1);
  endtask

  task automatic test_move_and_ignored_start();
    run_mt(3'b100, 32'hAAAA_0000, 1'b0, "mthi");
    run_mt(3'b101, 32'h0000_5555, 1'b0, "mtlo");
    run_mt(3'b110, 32'h1111_1111, 1'b0, "noop_110");
    run_mt(3'b100, 32'h2222_2222, 1'b1, "mthi_with_abort");
    run_op(3'b000, 32'h0001_0003, 32'hFFFF_0007, "mult_start_ignored", 5);
  endtask

  task automatic test_abort();
    run_cancel(3'b011, 32'd1000, 32'd3, 10, 1'b0, "abort_calc");
    run_op(3'b011, 32'h55, 32'd0, "divu_zero_before_fix_abort", -1);
    run_cancel(3'b011, 32'd50, 32'd5, LAT - 1, 1'b0, "abort_in_fix");
    run_cancel(3'b011, 32'd1000, 32'd3, 10, 1'b1, "rst_mid_op");
    run_mt(3'b011, 32'd77, 1'b1, "divu_start_with_abort");
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 6));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = '1; end
        2: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if (o[2]) run_mt(o, x, 1'b0, "rand_move");
      else      run_op(o, x, y, "rand_op", -1);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_multiply();
    test_move_and_ignored_start();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
